program_sequencer: RTL

Fetch/issue controller that drives the execution unit from a program ROM. It owns the program counter and fetches 12-bit instruction words (4-bit opcode, 8-bit operand) through a valid-qualified ROM read port. It presents each instruction to the execution unit with a one-cycle `start` strobe and applies skip-next decisions returned by the datapath. It sits between the SPI-loaded program ROM and the execution unit, under top-level run/halt control.

---
 rtl/seq_pkg.sv | 27 ++
 rtl/program_counter.sv | 38 +++
 rtl/program_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: definitions shared by the program sequencer and its sub-modules.
//   - seq_state_t   : sequencer FSM states. ST_STEP_WAIT exists only when
//                     SEQ_SINGLE_STEP_EN is defined.
//   - OP_HLT/OP_NOP : opcode constants.
//   - *_FIELD_LSB   : bit position of each instruction field, counted in units
//                     of the opcode width. The word is {opcode, operand}, and
//                     the operand is twice as wide as the opcode.
package seq_pkg;

  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [3:0] OP_NOP = 4'h0;

  localparam int OPC_FIELD_LSB = 2;
  localparam int OPR_FIELD_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXEC      = 3'd2,
    ST_HALTED    = 3'd3
`ifdef SEQ_SINGLE_STEP_EN
    ,
    ST_STEP_WAIT = 3'd4
`endif
  } seq_state_t;

endpackage

// File: rtl/program_counter.sv
// program_counter: holds the instruction address. It can be cleared, or it
// can advance by one or by two. The count wraps modulo 2^ADDR_W.
// Ports:
//   clk, reset : clock and asynchronous active-high reset (clears to 0)
//   i_clear    : load 0 (takes priority over i_advance)
//   i_advance  : step to the next instruction
//   i_skip     : with i_advance, step by two instead of one
//   o_pc       : current program counter
module program_counter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic              i_skip,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_step;

  assign w_step = i_skip ? ADDR_W'(2) : ADDR_W'(1);

  // The add truncates to ADDR_W bits, so 31+1 gives 0 and 31+2 gives 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= '0;
    end else if (i_clear) begin
      r_pc <= '0;
    end else if (i_advance) begin
      r_pc <= r_pc + w_step;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: fetch/issue controller between the program ROM and the
// execution unit.
// Optional feature: define SEQ_SINGLE_STEP_EN to add the `step` input and the
// STEP_WAIT state. In that mode each issued instruction waits for `step`
// before the next fetch.
// Ports:
//   clk, reset         : clock and asynchronous active-high reset
//   run, halt_req      : run request (from IDLE/HALTED) and stop request
//   step               : single-step advance (SEQ_SINGLE_STEP_EN only)
//   rom_en, rom_addr   : ROM read request and address (address = PC)
//   rom_data, rom_valid: instruction word {opcode, operand} and its valid flag
//   opcode, operand    : issued instruction, held until the next capture
//   start              : one-cycle issue strobe
//   skip               : datapath skip-next, sampled in the start cycle
//   busy, done         : activity flag and halt-entry pulse
module program_sequencer
  import seq_pkg::*;
#(
  parameter int ROM_ADDRESS_WIDTH = 5,
  parameter int INPUT_DATA_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          halt_req,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                          step,
`endif
  output logic                          rom_en,
  output logic [ROM_ADDRESS_WIDTH-1:0]  rom_addr,
  input  logic [3*INPUT_DATA_WIDTH-1:0] rom_data,
  input  logic                          rom_valid,
  output logic [INPUT_DATA_WIDTH-1:0]   opcode,
  output logic [2*INPUT_DATA_WIDTH-1:0] operand,
  output logic                          start,
  input  logic                          skip,
  output logic                          busy,
  output logic                          done
);

  seq_state_t                    r_state;
  logic                          r_rom_en;
  logic                          r_start;
  logic                          r_busy;
  logic                          r_done;
  logic [INPUT_DATA_WIDTH-1:0]   r_opcode;
  logic [2*INPUT_DATA_WIDTH-1:0] r_operand;

  logic                          w_pc_clear;
  logic                          w_pc_adv;
  logic [ROM_ADDRESS_WIDTH-1:0]  w_pc;
  logic [INPUT_DATA_WIDTH-1:0]   w_rom_opc;
  logic [2*INPUT_DATA_WIDTH-1:0] w_rom_opr;

  assign w_rom_opc = rom_data[OPC_FIELD_LSB*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
  assign w_rom_opr = rom_data[OPR_FIELD_LSB*INPUT_DATA_WIDTH +: 2*INPUT_DATA_WIDTH];

  // PC is cleared on a start from IDLE/HALTED. It advances only in EXEC, so
  // PC stays put after a halt in FETCH and after capturing HLT.
  assign w_pc_clear = ((r_state == ST_IDLE) || (r_state == ST_HALTED)) && run && !halt_req;
  assign w_pc_adv   = (r_state == ST_EXEC);

  program_counter #(
    .ADDR_W (ROM_ADDRESS_WIDTH)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_pc_clear),
    .i_advance (w_pc_adv),
    .i_skip    (skip),
    .o_pc      (w_pc)
  );

  // Outputs are registered. Each one is set on the transition into the state
  // that owns it, so it lines up with that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rom_en  <= 1'b0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_opcode  <= '0;
      r_operand <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HALTED: begin
          if (run && !halt_req) begin
            r_state  <= ST_FETCH;
            r_rom_en <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        ST_FETCH: begin
          // A halt request abandons the outstanding read, even one that
          // completes in this same cycle.
          if (halt_req) begin
            r_state  <= ST_HALTED;
            r_rom_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else if (rom_valid) begin
            r_rom_en <= 1'b0;
            if (w_rom_opc == INPUT_DATA_WIDTH'(OP_HLT)) begin
              r_state <= ST_HALTED;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state   <= ST_EXEC;
              r_opcode  <= w_rom_opc;
              r_operand <= w_rom_opr;
              r_start   <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (halt_req) begin
            r_state <= ST_HALTED;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
`ifdef SEQ_SINGLE_STEP_EN
            r_state  <= ST_STEP_WAIT;
`else
            r_state  <= ST_FETCH;
            r_rom_en <= 1'b1;
`endif
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        ST_STEP_WAIT: begin
          if (halt_req) begin
            r_state <= ST_HALTED;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (step) begin
            r_state  <= ST_FETCH;
            r_rom_en <= 1'b1;
          end
        end
`endif
        default: begin
          r_state  <= ST_IDLE;
          r_rom_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign rom_en   = r_rom_en;
  assign rom_addr = w_pc;
  assign opcode   = r_opcode;
  assign operand  = r_operand;
  assign start    = r_start;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
